rf_writeback_ctrl: RTL and testbench

Writeback controller for the 32×32 register bank. Shares the bank's single write port (write flag / write address / write data) between the ALU and the load/store unit using round-robin arbitration with valid/ready handshakes. Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards. Sits between the execute/memory stages and the register bank write port.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_writeback_ctrl_rr_arb2.sv | 51 +++++
 rtl/rf_writeback_ctrl.sv | 127 ++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-bank writeback controller.
//   DATA_W / ADDR_W / NUM_REGS : register width, address width, bank depth
//   wb_src_t                   : writeback source, used as the arbiter pointer
//   REG_ZERO                   : the hardwired-zero register address
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_writeback_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests (bit 0 = ALU, bit 1 = MEM)
//   accept     : a granted transfer completed this cycle
//   grant[1:0] : one-hot (or zero) grant, combinational from req and pointer
// ---------------------------------------------------------------------------
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  wb_src_t ptr_q;
  wb_src_t ptr_d;

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (ptr_q == SRC_ALU) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // After a transfer the other source becomes preferred; otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = grant[0] ? SRC_MEM : SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl
// Shares the register bank's single write port between the ALU and the
// load/store unit (round-robin, valid/ready), and tracks pending writes so
// decode can stall on RAW/WAW hazards.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   alu_valid/ready/addr/data     : ALU writeback request
//   mem_valid/ready/addr/data     : load writeback request
//   issue_valid/ready/addr        : decode reserving a destination register
//   query_a/b, busy_a/b           : source-operand pending lookups
//   rf_we/rf_waddr/rf_wdata       : registered bank write port
// ---------------------------------------------------------------------------
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] query_a,
  input  logic [ADDR_W-1:0] query_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  logic [1:0]          grant;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  logic                rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0] pending_q,  pending_d;

  logic                commit_hit;
  logic                issue_fire;

  // ---------------------------------------------------------------- arbiter
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({mem_valid, alu_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign alu_ready = grant[0];
  assign mem_ready = grant[1];
  assign accept    = |grant;

  // ------------------------------------------------------ output register
  always_comb begin
    sel_addr   = grant[1] ? mem_addr : alu_addr;
    sel_data   = grant[1] ? mem_data : alu_data;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (accept) begin
      // Writes to the zero register are consumed but never reach the bank.
      rf_we_d    = (sel_addr != ZERO_ADDR);
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  // ------------------------------------------------------------ scoreboard
  // A reservation may proceed in the very cycle the blocking write commits.
  assign commit_hit  = rf_we_q && (rf_waddr_q == issue_addr);
  assign issue_ready = rst_n && ((issue_addr == ZERO_ADDR) ||
                                 !pending_q[issue_addr] || commit_hit);
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    // Applied after the clear so a same-address set wins.
    if (issue_fire && (issue_addr != ZERO_ADDR)) begin
      pending_d[issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign busy_a = rst_n && (query_a != ZERO_ADDR) && pending_q[query_a];
  assign busy_b = rst_n && (query_b != ZERO_ADDR) && pending_q[query_b];

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
module tb_rf_writeback_ctrl;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_addr;
  logic [4:0]  query_a, query_b;
  logic        busy_a, busy_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_cmp = 0;
  int n_err = 0;

  rf_writeback_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_addr  (issue_addr),
    .query_a     (query_a),
    .query_b     (query_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ear;
    logic        emr;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_addr    = 5'd0;
    alu_data    = 32'd0;
    mem_valid   = 1'b0;
    mem_addr    = 5'd0;
    mem_data    = 32'd0;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
  endtask

  initial begin
    // Pointer starts at ALU; pointer moves to the other source after each grant.
    vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd7,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hAAAA0010, 1'b0, 1'b1, 1'b1, 5'd10, 32'hAAAA0010};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,       1'b1, 1'b0, 1'b1, 5'd3,  32'h33};
    vecs[4] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,       1'b0, 1'b1, 1'b1, 5'd4,  32'h44};
    vecs[5] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,       1'b1, 1'b0, 1'b1, 5'd3,  32'h33};
    vecs[6] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,       1'b0, 1'b1, 1'b1, 5'd4,  32'h44};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h12345678, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[8] = '{1'b1, 5'd0,  32'h5555,     1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[9] = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2,  32'h22,       1'b0, 1'b1, 1'b1, 5'd2,  32'h22};

    // ---------------------------------------------------------- reset
    rst_n       = 1'b0;
    idle_inputs();
    alu_valid   = 1'b1;
    alu_addr    = 5'd7;
    mem_valid   = 1'b1;
    mem_addr    = 5'd8;
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    query_a     = 5'd9;
    query_b     = 5'd7;
    #1;
    chk("rst_alu_ready",   {31'd0, alu_ready},   32'd0);
    chk("rst_mem_ready",   {31'd0, mem_ready},   32'd0);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_busy_a",      {31'd0, busy_a},      32'd0);
    chk("rst_busy_b",      {31'd0, busy_b},      32'd0);
    chk("rst_rf_we",       {31'd0, rf_we},       32'd0);
    chk("rst_rf_waddr",    {27'd0, rf_waddr},    32'd0);
    chk("rst_rf_wdata",    rf_wdata,             32'd0);
    $display("reset: checked outputs held low");
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rf_we",  {31'd0, rf_we},  32'd0);
    chk("idle_busy_a", {31'd0, busy_a}, 32'd0);
    $display("idle after reset: rf_we=%0b busy_a=%0b", rf_we, busy_a);

    // ------------------------------------------------- arbitration table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      alu_valid = vecs[i].av;
      alu_addr  = vecs[i].aa;
      alu_data  = vecs[i].ad;
      mem_valid = vecs[i].mv;
      mem_addr  = vecs[i].ma;
      mem_data  = vecs[i].md;
      #1;
      chk($sformatf("vec%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].ear});
      chk($sformatf("vec%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].emr});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].ewe});
      if (vecs[i].ewe) begin
        chk($sformatf("vec%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].ewa});
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].ewd);
      end
      $display("vec %0d: av=%0b mv=%0b -> ar=%0b mr=%0b we=%0b waddr=%0d wdata=%08h",
               i, vecs[i].av, vecs[i].mv, alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata);
    end

    // rf_we drops one cycle after a single write
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("post_table_rf_we", {31'd0, rf_we}, 32'd0);

    // ------------------------------------------------------ scoreboard
    @(negedge clk);
    query_a     = 5'd9;
    query_b     = 5'd0;
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    #1;
    chk("sb_busy_before", {31'd0, busy_a}, 32'd0);
    chk("sb_issue1_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk); #1;
    chk("sb_busy_after_issue", {31'd0, busy_a}, 32'd1);
    chk("sb_issue2_stall", {31'd0, issue_ready}, 32'd0);
    $display("scoreboard: issue r9 -> busy_a=%0b issue_ready=%0b", busy_a, issue_ready);

    // ALU write to r9 while the second issue stays stalled
    @(negedge clk);
    alu_valid = 1'b1;
    alu_addr  = 5'd9;
    alu_data  = 32'h99;
    #1;
    chk("sb_stall_held", {31'd0, issue_ready}, 32'd0);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    chk("sb_commit_rf_we", {31'd0, rf_we}, 32'd1);
    chk("sb_commit_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("sb_commit_busy_a", {31'd0, busy_a}, 32'd1);
    $display("scoreboard: commit r9 cycle -> issue_ready=%0b busy_a=%0b", issue_ready, busy_a);
    // re-issue fires at this edge together with the commit: set wins
    @(posedge clk); #1;
    chk("sb_set_wins", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    issue_valid = 1'b0;
    query_b     = 5'd9;
    #1;
    chk("sb_busy_b", {31'd0, busy_b}, 32'd1);

    // commit r9 again via MEM; busy falls two cycles after acceptance
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 5'd9;
    mem_data  = 32'h77;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("sb_mem_rf_we", {31'd0, rf_we}, 32'd1);
    chk("sb_busy_in_commit", {31'd0, busy_a}, 32'd1);
    @(posedge clk); #1;
    chk("sb_busy_cleared", {31'd0, busy_a}, 32'd0);
    $display("scoreboard: mem commit r9 -> busy_a=%0b", busy_a);

    // issue to r0 never sets busy
    @(negedge clk);
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    query_a     = 5'd0;
    #1;
    chk("zero_issue_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk); #1;
    chk("zero_busy_a", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    $display("zero register issue: busy_a=%0b", busy_a);

    // ------------------------------------------------------ async reset
    @(negedge clk);
    issue_valid = 1'b1;
    issue_addr  = 5'd5;
    @(negedge clk);
    issue_addr  = 5'd9;
    alu_valid   = 1'b1;
    alu_addr    = 5'd12;
    alu_data    = 32'hC0FFEE;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    query_a     = 5'd5;
    query_b     = 5'd9;
    #1;
    chk("ar_pre_busy_a", {31'd0, busy_a}, 32'd1);
    chk("ar_pre_busy_b", {31'd0, busy_b}, 32'd1);
    chk("ar_pre_rf_we",  {31'd0, rf_we},  32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_rf_we",  {31'd0, rf_we},  32'd0);
    chk("ar_busy_a", {31'd0, busy_a}, 32'd0);
    chk("ar_busy_b", {31'd0, busy_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_cleared_busy_a", {31'd0, busy_a}, 32'd0);
    chk("ar_cleared_busy_b", {31'd0, busy_b}, 32'd0);
    $display("async reset: rf_we=%0b busy_a=%0b busy_b=%0b", rf_we, busy_a, busy_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
